// File: rtl/drum_spi_pkg.sv
// Shared types and constants for the drum-pad SPI receive master.
package drum_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCK_LOW,
    ST_SCK_HIGH,
    ST_ACK,
    ST_WAIT_RELEASE,
    ST_HOLD
  } state_e;

  localparam int unsigned DRUM_CODE_W     = 4;
  localparam int unsigned DRUM_MAX_CODE   = 7;
  localparam int unsigned DEF_CLK_DIV     = 4;
  localparam int unsigned DEF_ACK_TIMEOUT = 1024;

  // A received byte is a drum command only when it encodes 0..DRUM_MAX_CODE.
  function automatic logic is_valid_code(input logic [7:0] b);
    return b <= 8'(DRUM_MAX_CODE);
  endfunction

endpackage

// File: rtl/drum_spi_master_if.sv
// SPI link to the drum slave plus the command hand-off to the consumer.
interface drum_spi_master_if;

  logic                                 sck;
  logic                                 sdo;
  logic                                 sdi;
  logic                                 load;
  logic                                 done;
  logic                                 cmd_valid;
  logic                                 cmd_ready;
  logic [drum_spi_pkg::DRUM_CODE_W-1:0] cmd_code;
  logic                                 cmd_error;

  modport master (
    output sck, sdo, load, cmd_valid, cmd_code, cmd_error,
    input  sdi, done, cmd_ready
  );

  modport slave (
    input  sck, sdo, load, cmd_valid, cmd_code, cmd_error,
    output sdi, done, cmd_ready
  );

endinterface

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous input bit.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Resample the asynchronous input twice before anyone uses it.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so both flops
    // sample their pre-edge values; blocking here would collapse the chain.
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/drum_spi_master.sv
// SPI master that pulls one byte per slave "done" request, acknowledges it
// with "load", and presents valid drum codes on a valid/ready interface.
module drum_spi_master
  import drum_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV     = DEF_CLK_DIV,
  parameter int unsigned ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  drum_spi_master_if.master bus
);

  localparam int unsigned     TO_W     = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [7:0]      DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(ACK_TIMEOUT - 1);

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [7:0]             r_div_cnt;
  logic [2:0]             r_bit_cnt;
  logic [TO_W-1:0]        r_to_cnt;
  logic [7:0]             r_shift;
  logic                   r_cmd_valid;
  logic [DRUM_CODE_W-1:0] r_cmd_code;
  logic                   r_cmd_error;

  logic w_sdi_s;
  logic w_done_s;
  logic w_div_last;
  logic w_shift_en;
  logic w_timeout;
  logic w_start;

  sync2 u_sync_sdi (
    .clk   (clk),
    .reset (reset),
    .i_d   (bus.sdi),
    .o_q   (w_sdi_s)
  );

  sync2 u_sync_done (
    .clk   (clk),
    .reset (reset),
    .i_d   (bus.done),
    .o_q   (w_done_s)
  );

  assign w_div_last = (r_div_cnt == DIV_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic and per-cycle strobes for the datapath.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case leaves one unassigned and infers a latch.
    w_state_nxt = r_state;
    w_shift_en  = 1'b0;
    w_timeout   = 1'b0;
    w_start     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        // A pending command blocks the next transfer (backpressure).
        if (w_done_s && !r_cmd_valid) begin
          w_start     = 1'b1;
          w_state_nxt = ST_SCK_LOW;
        end
      end
      ST_SCK_LOW: begin
        if (w_div_last) w_state_nxt = ST_SCK_HIGH;
      end
      ST_SCK_HIGH: begin
        // Sample once, right after the rising edge; the slave changed sdi
        // after the previous falling edge, so it has had a full low phase.
        w_shift_en = (r_div_cnt == 8'd0);
        if (w_div_last) w_state_nxt = (r_bit_cnt == 3'd7) ? ST_ACK : ST_SCK_LOW;
      end
      ST_ACK: begin
        w_state_nxt = ST_WAIT_RELEASE;
      end
      ST_WAIT_RELEASE: begin
        if (!w_done_s) begin
          w_state_nxt = ST_HOLD;
        end else if (r_to_cnt == TO_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_HOLD: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Timing counters and the MSB-first receive shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_to_cnt  <= '0;
      r_shift   <= '0;
    end else begin
      if (w_state_nxt != r_state) r_div_cnt <= '0;
      else if (r_state == ST_SCK_LOW || r_state == ST_SCK_HIGH) r_div_cnt <= r_div_cnt + 8'd1;

      if (w_start) r_bit_cnt <= '0;
      else if (r_state == ST_SCK_HIGH && w_div_last) r_bit_cnt <= r_bit_cnt + 3'd1;

      if (r_state == ST_WAIT_RELEASE) r_to_cnt <= r_to_cnt + 1'b1;
      else                            r_to_cnt <= '0;

      if (w_shift_en) r_shift <= {r_shift[6:0], w_sdi_s};
    end
  end

  // Command hand-off and the one-cycle error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmd_valid <= 1'b0;
      r_cmd_code  <= '0;
      r_cmd_error <= 1'b0;
    end else begin
      r_cmd_error <= w_timeout || (r_state == ST_HOLD && !is_valid_code(r_shift));
      if (r_state == ST_HOLD && is_valid_code(r_shift)) begin
        r_cmd_valid <= 1'b1;
        r_cmd_code  <= r_shift[DRUM_CODE_W-1:0];
      end else if (r_cmd_valid && bus.cmd_ready) begin
        r_cmd_valid <= 1'b0;
      end
    end
  end

  assign bus.sck       = (r_state == ST_SCK_HIGH);
  assign bus.load      = (r_state == ST_ACK) || (r_state == ST_WAIT_RELEASE);
  assign bus.sdo       = 1'b0;
  assign bus.cmd_valid = r_cmd_valid;
  assign bus.cmd_code  = r_cmd_code;
  assign bus.cmd_error = r_cmd_error;

endmodule

// File: doc/drum_spi_master.md
DRUM_SPI_MASTER -- requirements
Module: drum_spi_master

Interface
REQ-001 Parameter CLK_DIV, default 4: clk cycles per SCK half-period; legal range 4..255.
REQ-002 Parameter ACK_TIMEOUT, default 1024: max clk cycles to wait for done low after load rises.
REQ-003 clk  input  1  system clock; one clock domain; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 sck  output  1  SPI clock to slave; CPOL=0, CPHA=0.
REQ-006 sdo  output  1  MOSI; driven constant 0.
REQ-007 sdi  input  1  MISO from slave; asynchronous.
REQ-008 load  output  1  acknowledge to slave.
REQ-009 done  input  1  slave data-ready; asynchronous.
REQ-010 cmd_valid  output  1  received command available.
REQ-011 cmd_ready  input  1  consumer accepts the command while cmd_valid is high.
REQ-012 cmd_code  output  4  received drum code, low nibble of received byte.
REQ-013 cmd_error  output  1  one-cycle pulse on a protocol or format error.

Function
REQ-014 Synchronise sdi and done through 2-flop synchronisers; all logic uses only the synchronised versions.
REQ-015 FSM states: IDLE, SCK_LOW, SCK_HIGH, ACK, WAIT_RELEASE, HOLD.
REQ-016 IDLE -> SCK_LOW when synced done=1 and cmd_valid=0; otherwise stay in IDLE (backpressure).
REQ-017 SCK_LOW: sck=0 for CLK_DIV cycles, then -> SCK_HIGH.
REQ-018 SCK_HIGH: sck=1 for CLK_DIV cycles; on the first cycle of the state, shift synced sdi into an 8-bit register MSB-first.
REQ-019 After the 8th SCK_HIGH -> ACK; exactly 8 sck rising edges per transaction.
REQ-020 A 3-bit bit counter counts 0..7; it resets to 0 on entry from IDLE.
REQ-021 ACK: load=1; -> WAIT_RELEASE the next cycle.
REQ-022 WAIT_RELEASE: load held 1 until synced done=0, then -> HOLD.
REQ-023 If WAIT_RELEASE lasts ACK_TIMEOUT cycles: cmd_error pulse, load=0, byte discarded, -> IDLE.
REQ-024 HOLD: load=0.
REQ-025 HOLD, valid byte: if byte[7:3]==0, set cmd_valid=1 and cmd_code=byte[3:0].
REQ-026 HOLD, invalid byte: otherwise pulse cmd_error and leave cmd_valid=0.
REQ-027 HOLD always -> IDLE next cycle.
REQ-028 cmd_valid/cmd_code hold stable until the cycle where cmd_valid&&cmd_ready; cmd_valid clears the following cycle.
REQ-029 A new transaction starts only when cmd_valid=0; acceptance and a new start in the same cycle are not allowed.
REQ-030 If done falls during SCK_LOW or SCK_HIGH, complete all 8 bits, then treat as in REQ-022; done is already low, so WAIT_RELEASE exits immediately.
REQ-031 Minimum transaction latency from synced done rise to cmd_valid: 16*CLK_DIV + 3 cycles plus WAIT_RELEASE duration.

Reset
REQ-032 Reset values: state=IDLE, sck=0, load=0, sdo=0, cmd_valid=0, cmd_code=0, cmd_error=0, counters=0, shift register=0, synchronisers=0.
REQ-033 Reset mid-transaction aborts immediately; load and sck return to 0 on the next edge and no cmd_valid is produced.

Structure
REQ-034 Package drum_spi_pkg holds the FSM state enum, DRUM_CODE_W=4, DRUM_MAX_CODE=7 and default CLK_DIV/ACK_TIMEOUT.
REQ-035 One sub-module, sync2 (2-flop synchroniser), instantiated once for sdi and once for done.
REQ-036 Expected implementation size: 150-250 lines.

Verification
REQ-037 Bench uses a behavioural slave model: MSB-first shift, data changes after SCK falling edge, done drops one cycle after load rises.
REQ-038 Slave presents 0x05 -> 8 sck pulses, each high/low CLK_DIV=4 cycles; one load pulse; cmd_valid with cmd_code=5; cmd_error=0.
REQ-039 cmd_ready held 0 while slave presents 0x03 then 0x06 -> 0x03 stays on the outputs; no sck toggles until it is accepted; then 0x06 is received.
REQ-040 Slave presents 0x8A -> one cmd_error pulse; cmd_valid stays 0; load cycles normally.
REQ-041 Slave never drops done, ACK_TIMEOUT=16 -> cmd_error after 16 WAIT_RELEASE cycles; load returns to 0; FSM returns to IDLE.
REQ-042 Reset asserted after 4 sck pulses -> sck=0 and load=0 next cycle; no cmd_valid; the next transaction of 0x07 is received correctly.
